// File: rtl/num_entry.sv
// ---------------------------------------------------------------------------
// num_entry
//
// Keypad-side number builder for the calculator datapath. Decoded key events
// arrive one at a time. Digits accumulate into an unsigned decimal magnitude,
// and the minus key toggles a sign flag. The result is presented as a signed
// two's-complement operand for the ALU. The display path later reverses this
// step: it splits a result back into a magnitude and a negative flag.
//
// Parameters:
//   WIDTH       width of the signed output word (bit WIDTH-1 is the sign)
//   MAX_DIGITS  maximum significant decimal digits; 10^MAX_DIGITS-1 must fit
//               in WIDTH-1 bits
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   key_valid  a key event is present this cycle
//   key_code   0-9 digit, 10 minus, 11 clear, 12 enter, 13 backspace
//              (backspace only with BACKSPACE_EN); other codes are ignored
//   key_ready  block can take a key (accept = key_valid && key_ready)
//   num        signed operand, neg ? -mag : mag (registered)
//   neg        sign flag
//   digit_cnt  number of significant digits currently held
//   num_valid  one-cycle pulse when num is a completed operand
//   err        one-cycle pulse when a digit is refused at the digit limit
//
// Build option:
//   BACKSPACE_EN  when defined, code 13 removes the last digit. It divides
//                 mag by 10 with a bit-serial restoring divider that takes
//                 WIDTH-1 cycles. key_ready is low while the divider runs.
// ---------------------------------------------------------------------------
module num_entry #(
    parameter int WIDTH      = 25,
    parameter int MAX_DIGITS = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [4:0]       key_code,
    output logic             key_ready,
    output logic [WIDTH-1:0] num,
    output logic             neg,
    output logic [3:0]       digit_cnt,
    output logic             num_valid,
    output logic             err
);

    localparam int MAG_W = WIDTH - 1;

    localparam logic [1:0] ST_ENTRY = 2'd0;
    localparam logic [1:0] ST_DONE  = 2'd1;

    localparam logic [4:0] KEY_MINUS = 5'd10;
    localparam logic [4:0] KEY_CLEAR = 5'd11;
    localparam logic [4:0] KEY_ENTER = 5'd12;

    localparam logic [3:0]       MAX_CNT = 4'(MAX_DIGITS);
    localparam logic [WIDTH-1:0] ZERO_W  = '0;
    localparam logic [MAG_W-1:0] ZERO_M  = '0;

`ifdef BACKSPACE_EN
    localparam logic [1:0] ST_DIV   = 2'd2;
    localparam logic [4:0] KEY_BACK = 5'd13;
    localparam int         CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 2);
`endif

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] mag_nxt;
    logic             neg_nxt;
    logic [3:0]       cnt_nxt;
    logic [WIDTH-1:0] num_nxt;
    logic             num_valid_nxt;
    logic             err_nxt;

    logic             accept;
    logic             is_digit;
    logic [3:0]       key_digit;
    logic [MAG_W-1:0] digit_ext;
    logic [MAG_W-1:0] mag_x10d;
    logic [WIDTH-1:0] mag_ext;

    // Key decode. A key counts only when it is presented and the block can
    // take it. Only a digit uses the low nibble of the code.
    assign accept    = key_valid && key_ready;
    assign is_digit  = (key_code <= 5'd9);
    assign key_digit = key_code[3:0];
    assign digit_ext = {{(MAG_W-4){1'b0}}, key_digit};

    // Append a digit: mag*10 + d. The x10 is two shifted adds
    // (x8 + x2), so no multiplier is built.
    assign mag_x10d = {mag[MAG_W-4:0], 3'b000} + {mag[MAG_W-2:0], 1'b0} + digit_ext;

`ifdef BACKSPACE_EN
    logic [MAG_W-1:0] dq;
    logic [MAG_W-1:0] dq_nxt;
    logic [3:0]       rem;
    logic [3:0]       rem_nxt;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_cnt_nxt;
    logic [4:0]       rem_shift;
    logic             q_bit;
    logic [3:0]       rem_step;
    logic [MAG_W-1:0] quot_step;

    // One restoring-division step by 10. The next dividend bit shifts into
    // the partial remainder. When the result reaches the divisor, the divisor
    // is subtracted and a 1 quotient bit is produced. The dividend shifts out
    // of dq at the top while quotient bits shift in at the bottom. After
    // WIDTH-1 steps, dq holds the quotient.
    assign rem_shift = {rem, dq[MAG_W-1]};
    assign q_bit     = (rem_shift >= 5'd10);
    assign rem_step  = q_bit ? 4'(rem_shift - 5'd10) : rem_shift[3:0];
    assign quot_step = {dq[MAG_W-2:0], q_bit};

    // The only time the block stalls the keypad is while the divider runs.
    assign key_ready = (state != ST_DIV);
`else
    // There is no multi-cycle operation, so every key can be taken at once.
    assign key_ready = 1'b1;
`endif

    // Next-state logic for the entry FSM. Every register holds its value by
    // default. The two pulses default low, so each one lasts exactly one
    // cycle after the key that caused it.
    always_comb begin
        state_nxt     = state;
        mag_nxt       = mag;
        neg_nxt       = neg;
        cnt_nxt       = digit_cnt;
        num_valid_nxt = 1'b0;
        err_nxt       = 1'b0;
`ifdef BACKSPACE_EN
        dq_nxt        = dq;
        rem_nxt       = rem;
        div_cnt_nxt   = div_cnt;
`endif
        case (state)
            ST_ENTRY: begin
                if (accept) begin
                    if (is_digit) begin
                        if (digit_cnt < MAX_CNT) begin
                            mag_nxt = mag_x10d;
                            if ((mag != ZERO_M) || (key_digit != 4'd0)) begin
                                cnt_nxt = digit_cnt + 4'd1;
                            end
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (key_code == KEY_MINUS) begin
                        neg_nxt = ~neg;
                    end else if (key_code == KEY_ENTER) begin
                        num_valid_nxt = 1'b1;
                        state_nxt     = ST_DONE;
                    end else if (key_code == KEY_CLEAR) begin
                        mag_nxt = ZERO_M;
                        neg_nxt = 1'b0;
                        cnt_nxt = 4'd0;
                    end
`ifdef BACKSPACE_EN
                    else if ((key_code == KEY_BACK) && (digit_cnt != 4'd0)) begin
                        dq_nxt      = mag;
                        rem_nxt     = 4'd0;
                        div_cnt_nxt = '0;
                        state_nxt   = ST_DIV;
                    end
`endif
                end
            end

            ST_DONE: begin
                // The finished operand stays on num until a new key arrives.
                // A digit or a minus starts a new operand instead of editing
                // the finished one.
                if (accept) begin
                    if (is_digit) begin
                        mag_nxt   = digit_ext;
                        neg_nxt   = 1'b0;
                        cnt_nxt   = (key_digit != 4'd0) ? 4'd1 : 4'd0;
                        state_nxt = ST_ENTRY;
                    end else if (key_code == KEY_MINUS) begin
                        mag_nxt   = ZERO_M;
                        neg_nxt   = 1'b1;
                        cnt_nxt   = 4'd0;
                        state_nxt = ST_ENTRY;
                    end else if (key_code == KEY_ENTER) begin
                        num_valid_nxt = 1'b1;
                    end else if (key_code == KEY_CLEAR) begin
                        mag_nxt   = ZERO_M;
                        neg_nxt   = 1'b0;
                        cnt_nxt   = 4'd0;
                        state_nxt = ST_ENTRY;
                    end
                end
            end

`ifdef BACKSPACE_EN
            ST_DIV: begin
                // Keys are not accepted here. mag, and so num, keeps the old
                // value until the final step writes the quotient back.
                dq_nxt      = quot_step;
                rem_nxt     = rem_step;
                div_cnt_nxt = div_cnt + CNT_W'(1);
                if (div_cnt == DIV_LAST) begin
                    mag_nxt   = quot_step;
                    cnt_nxt   = digit_cnt - 4'd1;
                    state_nxt = ST_ENTRY;
                end
            end
`endif

            default: begin
                state_nxt = ST_ENTRY;
            end
        endcase
    end

    // num is registered from the next-state magnitude and sign, so it changes
    // on the same edge as the key that changes them.
    assign mag_ext = {1'b0, mag_nxt};
    assign num_nxt = neg_nxt ? (ZERO_W - mag_ext) : mag_ext;

    // State and output registers. An asynchronous reset clears everything,
    // including an unfinished division, and returns the block to an empty
    // entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ENTRY;
            mag       <= '0;
            neg       <= 1'b0;
            digit_cnt <= 4'd0;
            num       <= '0;
            num_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            mag       <= mag_nxt;
            neg       <= neg_nxt;
            digit_cnt <= cnt_nxt;
            num       <= num_nxt;
            num_valid <= num_valid_nxt;
            err       <= err_nxt;
        end
    end

`ifdef BACKSPACE_EN
    // Divider working registers. They are only meaningful in the divide
    // state, and they are loaded again each time a backspace is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq      <= '0;
            rem     <= 4'd0;
            div_cnt <= '0;
        end else begin
            dq      <= dq_nxt;
            rem     <= rem_nxt;
            div_cnt <= div_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_num_entry.sv
// ---------------------------------------------------------------------------
// tb_num_entry
//
// Directed bench for num_entry. A reference model works on whole integers.
// It keeps the value, the sign, a pending-divide countdown and a finished
// flag, and it derives the digit count as the decimal length of the value.
// A compare process checks every DUT output against this model on each
// falling edge. Hand-computed literal checks pin the model itself.
// ---------------------------------------------------------------------------
module tb_num_entry;

    localparam int WIDTH      = 25;
    localparam int MAX_DIGITS = 7;

`ifdef BACKSPACE_EN
    localparam bit BACK = 1'b1;
`else
    localparam bit BACK = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             key_valid;
    logic [4:0]       key_code;
    logic             key_ready;
    logic [WIDTH-1:0] num;
    logic             neg;
    logic [3:0]       digit_cnt;
    logic             num_valid;
    logic             err;

    int checks = 0;
    int errors = 0;

    num_entry #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .num       (num),
        .neg       (neg),
        .digit_cnt (digit_cnt),
        .num_valid (num_valid),
        .err       (err)
    );

    // Free-running clock; inputs change and outputs are sampled on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    longint m_mag      = 0;
    bit     m_neg      = 1'b0;
    bit     m_done     = 1'b0;
    int     m_div_left = 0;
    bit     m_valid    = 1'b0;
    bit     m_err      = 1'b0;
    int     k;
    logic [WIDTH-1:0] e_num;

    function automatic int ndig(input longint v);
        int n = 0;
        longint t = v;
        while (t > 0) begin
            n++;
            t = t / 10;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Model update: it reacts to each accepted key as described for the
    // calculator keypad. A backspace starts a WIDTH-1 cycle busy window and
    // then divides the value by 10.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mag = 0; m_neg = 1'b0; m_done = 1'b0;
            m_div_left = 0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (m_div_left > 0) begin
                m_div_left--;
                if (m_div_left == 0) m_mag = m_mag / 10;
            end else if (key_valid) begin
                k = int'(key_code);
                if (k <= 9) begin
                    if (m_done) begin
                        m_mag = k; m_neg = 1'b0; m_done = 1'b0;
                    end else if (ndig(m_mag) < MAX_DIGITS) begin
                        m_mag = m_mag * 10 + k;
                    end else begin
                        m_err = 1'b1;
                    end
                end else if (k == 10) begin
                    if (m_done) begin
                        m_mag = 0; m_neg = 1'b1; m_done = 1'b0;
                    end else begin
                        m_neg = !m_neg;
                    end
                end else if (k == 11) begin
                    m_mag = 0; m_neg = 1'b0; m_done = 1'b0;
                end else if (k == 12) begin
                    m_valid = 1'b1; m_done = 1'b1;
                end else if (k == 13 && BACK && !m_done && m_mag != 0) begin
                    m_div_left = WIDTH - 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            e_num = m_neg ? WIDTH'(-m_mag) : WIDTH'(m_mag);
            checkOutput("cyc_num", 32'(num), 32'(e_num));
            checkOutput("cyc_neg", 32'(neg), 32'(m_neg));
            checkOutput("cyc_digit_cnt", 32'(digit_cnt), 32'(ndig(m_mag)));
            checkOutput("cyc_num_valid", 32'(num_valid), 32'(m_valid));
            checkOutput("cyc_err", 32'(err), 32'(m_err));
            checkOutput("cyc_key_ready", 32'(key_ready), 32'(m_div_left == 0));
        end
    end

    // Watchdog so a stuck run still ends with a summary.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    int busy;

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 5'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_num", 32'(num), 32'd0);
        checkOutput("reset_ready", 32'(key_ready), 32'd1);
        checkOutput("reset_cnt", 32'(digit_cnt), 32'd0);

        $display("[TB] keys 1 2 3 enter");
        applyStimulus(5'd1); applyStimulus(5'd2); applyStimulus(5'd3);
        checkOutput("lit_num_123", 32'(num), 32'd123);
        checkOutput("lit_cnt_3", 32'(digit_cnt), 32'd3);
        applyStimulus(5'd12);
        checkOutput("lit_enter_valid", 32'(num_valid), 32'd1);
        @(negedge clk);
        checkOutput("lit_valid_end", 32'(num_valid), 32'd0);

        $display("[TB] keys 4 5 minus enter enter");
        applyStimulus(5'd4); applyStimulus(5'd5); applyStimulus(5'd10);
        applyStimulus(5'd12);
        checkOutput("lit_num_m45", 32'(num), 32'h1FFFFD3);
        checkOutput("lit_neg_1", 32'(neg), 32'd1);
        @(negedge clk);
        applyStimulus(5'd12);
        checkOutput("lit_reenter_valid", 32'(num_valid), 32'd1);
        checkOutput("lit_reenter_num", 32'(num), 32'h1FFFFD3);

        $display("[TB] minus-only operand then 0 0 7");
        applyStimulus(5'd11);
        applyStimulus(5'd10); applyStimulus(5'd12);
        checkOutput("lit_minus0_num", 32'(num), 32'd0);
        checkOutput("lit_minus0_neg", 32'(neg), 32'd1);
        applyStimulus(5'd0); applyStimulus(5'd0); applyStimulus(5'd7);
        checkOutput("lit_num_7", 32'(num), 32'd7);
        checkOutput("lit_cnt_1", 32'(digit_cnt), 32'd1);
        checkOutput("lit_neg_0", 32'(neg), 32'd0);

        $display("[TB] ignored keys");
        key_code = 5'd5;
        @(negedge clk);
        applyStimulus(5'd14); applyStimulus(5'd31);
        checkOutput("lit_ignored_num", 32'(num), 32'd7);

        $display("[TB] digit limit");
        applyStimulus(5'd11);
        for (int i = 0; i < 7; i++) applyStimulus(5'd9);
        checkOutput("lit_num_9999999", 32'(num), 32'd9999999);
        applyStimulus(5'd9);
        checkOutput("lit_limit_err", 32'(err), 32'd1);
        checkOutput("lit_limit_num", 32'(num), 32'd9999999);
        applyStimulus(5'd11);
        checkOutput("lit_clear_num", 32'(num), 32'd0);
        checkOutput("lit_clear_cnt", 32'(digit_cnt), 32'd0);

        $display("[TB] asynchronous reset mid-entry");
        applyStimulus(5'd5); applyStimulus(5'd6);
        checkOutput("lit_num_56", 32'(num), 32'd56);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("lit_async_num", 32'(num), 32'd0);
        checkOutput("lit_async_ready", 32'(key_ready), 32'd1);
        checkOutput("lit_async_cnt", 32'(digit_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(5'd3);
        checkOutput("lit_after_reset_num", 32'(num), 32'd3);

        $display("[TB] backspace");
        applyStimulus(5'd11);
        applyStimulus(5'd13);
        checkOutput("lit_back_empty_ready", 32'(key_ready), 32'd1);
        applyStimulus(5'd1); applyStimulus(5'd2); applyStimulus(5'd3);
        applyStimulus(5'd13);
        busy = 0;
        while (key_ready == 1'b0 && busy < 100) begin
            busy++;
            if (busy == 2) begin
                key_valid = 1'b1;
                key_code  = 5'd9;
            end
            if (busy == 6) key_valid = 1'b0;
            @(negedge clk);
        end
        key_valid = 1'b0;
        checkOutput("lit_busy_cycles", 32'(busy), BACK ? 32'd24 : 32'd0);
        checkOutput("lit_back_num", 32'(num), BACK ? 32'd12 : 32'd123);
        checkOutput("lit_back_cnt", 32'(digit_cnt), BACK ? 32'd2 : 32'd3);
        checkOutput("lit_back_ready", 32'(key_ready), 32'd1);
        applyStimulus(5'd4);
        applyStimulus(5'd12);
        applyStimulus(5'd13);
        checkOutput("lit_back_done_ready", 32'(key_ready), 32'd1);
        checkOutput("lit_back_done_num", 32'(num), BACK ? 32'd124 : 32'd1234);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/num_entry.md
Name: num_entry

Overview:
Keypad-side number builder for the calculator datapath. Accepts decoded key events (digits, minus, clear, enter) one at a time and accumulates a decimal magnitude with a sign flag. Emits the value as a signed two's-complement word. It is the inverse of the display-side sign/magnitude split: operands built here feed the ALU, and the display path later converts results back to magnitude plus a negative flag.

Parameters:
WIDTH, 25, width of the signed output word; bit WIDTH-1 is the sign bit.
MAX_DIGITS, 7, maximum significant decimal digits. Must satisfy 10^MAX_DIGITS-1 < 2^(WIDTH-1).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  key event present this cycle
key_code  input  5  0-9 = digit, 10 = minus, 11 = clear, 12 = enter, 13 = backspace (only with the optional feature); all other codes are ignored
key_ready  output  1  block can accept a key; a key is accepted when key_valid && key_ready
num  output  WIDTH  signed value: neg ? -mag : mag
neg  output  1  sign flag; OP_MINUS entered
digit_cnt  output  4  count of significant digits currently held
num_valid  output  1  one-cycle pulse: num is a completed operand
err  output  1  one-cycle pulse: digit rejected because of the digit limit

Behaviour:
- Reset: rst_n is asynchronous and active-low, clock is clk. All outputs are 0 except key_ready=1. Internal mag=0. State is ENTRY.
- Internal state: mag, unsigned WIDTH-1 bits. States are ENTRY, DONE and DIV (DIV exists only with the optional feature).
- Latency: every accepted key updates num, neg, digit_cnt, num_valid and err on the next rising edge. num is registered and computed from the next-state mag and neg.
- Keys with key_valid=0, or with an unused code, change nothing.
- Digit d in ENTRY:
  - If digit_cnt < MAX_DIGITS: mag <= mag*10 + d. Multiply by 10 as (mag<<3)+(mag<<1); no multiplier.
  - digit_cnt increments only if mag!=0 or d!=0. Leading zeros do not count.
  - If digit_cnt == MAX_DIGITS: mag is unchanged and err pulses for 1 cycle.
- Minus in ENTRY: neg toggles. mag is unchanged.
- Enter in ENTRY: num_valid pulses for 1 cycle, state goes to DONE, and num/neg hold their values. An empty entry gives num=0 with neg as entered, so minus-only gives num=0, neg=1 and the display shows "-0".
- In DONE:
  - num and neg hold.
  - A digit starts a fresh operand: mag=d, neg=0, digit_cnt=(d!=0), state goes to ENTRY.
  - Minus starts a fresh operand: mag=0, neg=1, digit_cnt=0, state goes to ENTRY.
  - Enter pulses num_valid again with the same value.
  - Backspace is ignored.
- Clear in any state other than DIV: mag=0, neg=0, digit_cnt=0, num=0, state goes to ENTRY. No num_valid.
- num_valid and err are never high in the same cycle, since only one key is accepted per cycle.
- key_ready=1 in ENTRY and DONE.

Optional Feature:
Macro BACKSPACE_EN.
- Defined:
  - Code 13 in ENTRY with digit_cnt>0 enters DIV. In DIV, mag is divided by 10 with a restoring divider producing 1 quotient bit per cycle, over exactly WIDTH-1 cycles.
  - key_ready=0 from the cycle after accept through the last DIV cycle. Keys are not accepted during this window.
  - On the edge ending the last DIV cycle: mag=quotient, digit_cnt decrements, num is updated, key_ready=1, state goes to ENTRY. neg is unchanged.
  - Backspace with digit_cnt=0 is ignored. So is backspace in DONE.
  - Reset during DIV aborts to the reset state.
- Undefined: code 13 is ignored like any other unused code, DIV does not exist, and key_ready is constantly 1 after reset.

Test Plan:
- Keys 1,2,3,enter -> num=123, neg=0, digit_cnt=3; num_valid high exactly 1 cycle after the enter edge.
- Keys 4,5,minus,enter -> num=25'h1FFFFD3 (-45), neg=1. A second enter -> another num_valid pulse with the same value.
- Minus,enter from reset -> num=0, neg=1, num_valid pulse. Then 0,0,7 -> fresh operand, num=7, digit_cnt=1, neg=0.
- Eight 9 keys -> after the 7th, num=9999999. The 8th produces an err pulse and num is unchanged. Clear -> num=0, neg=0, digit_cnt=0.
- Assert rst_n low asynchronously mid-entry (num=56) -> outputs zero immediately, key_ready=1. After release, digit 3 -> num=3.
- BACKSPACE_EN: keys 1,2,3,backspace -> key_ready low for 24 cycles and a key presented then is not taken; afterwards num=12, digit_cnt=2. Without the macro, code 13 leaves num=123 and key_ready stays 1.
